// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle logical right-shift sequencer.
package shift_pkg;

    // Sequencer states: idle/accepting, stepping the shift, result held for handoff.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // Default per-cycle step size.
    localparam int STEP_DEF = 4;

    // Bits needed to encode a per-cycle step amount in the range 0..step.
    function automatic int step_amt_width(input int step);
        return $clog2(step + 1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Narrow per-cycle step shifter: logical right shift by at most STEP bits.
module shift_step
    import shift_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int STEP = STEP_DEF,
    localparam int KW   = step_amt_width(STEP)
) (
    input  logic [W-1:0]  a,
    input  logic [KW-1:0] amt,
    output logic [W-1:0]  y
);

    // amt never exceeds STEP, so the shift mux only spans STEP+1 positions.
    assign y = a >> amt;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle logical right-shift sequencer with valid/ready on both sides.
// The shift is applied in chunks of at most STEP bits per cycle, trading a
// full barrel shifter for a narrow step shifter plus a remaining-amount counter.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int STEP = STEP_DEF,
    localparam int SW   = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [SW-1:0] shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          busy
);

    localparam int KW = step_amt_width(STEP);

    shift_state_t  state_r;
    shift_state_t  state_nxt_s;
    logic [W-1:0]  data_r;
    logic [W-1:0]  data_nxt_s;
    logic [SW-1:0] rem_r;
    logic [SW-1:0] rem_nxt_s;
    logic [SW-1:0] rem_dec_s;
    logic [KW-1:0] k_s;
    logic [W-1:0]  step_y_s;
    logic          out_valid_r;
    logic          busy_r;
    logic          in_ready_s;
    logic          accept_s;

    // Requests are only taken in IDLE; held low while reset is asserted.
    assign in_ready_s = (state_r == IDLE) && !rst;
    assign accept_s   = in_valid && in_ready_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign y         = data_r;

    shift_step #(
        .W    (W),
        .STEP (STEP)
    ) u_step (
        .a   (data_r),
        .amt (k_s),
        .y   (step_y_s)
    );

    // Step amount k = min(rem, STEP); compare one bit wider so STEP == W cannot wrap.
    always_comb begin
        k_s = {KW{1'b0}};
        if ({1'b0, rem_r} >= (SW + 1)'(STEP)) begin
            k_s = KW'(STEP);
        end else begin
            k_s = KW'(rem_r);
        end
        rem_dec_s = rem_r - SW'(k_s);
    end

    // Next-state, data and remaining-amount selection for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        rem_nxt_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    data_nxt_s = a;
                    rem_nxt_s  = shamt;
                    if (shamt == {SW{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                data_nxt_s = step_y_s;
                rem_nxt_s  = rem_dec_s;
                if (rem_dec_s == {SW{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                data_nxt_s  = {W{1'b0}};
                rem_nxt_s   = {SW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered status outputs; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            data_r      <= {W{1'b0}};
            rem_r       <= {SW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            data_r      <= data_nxt_s;
            rem_r       <= rem_nxt_s;
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl (W=32, STEP=4): directed table,
// multi-cycle corner sequences and a randomized scoreboard.
module tb_shift_seq_ctrl;

    localparam int W    = 32;
    localparam int STEP = 4;
    localparam int SW   = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          busy;

    int errors;
    int checks;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] exp_y;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    shift_seq_ctrl #(
        .W    (W),
        .STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction: accept, wait for result, optional backpressure, handoff.
    task automatic do_op(input logic [31:0] ta, input logic [4:0] ts, input logic [31:0] ey,
                         input int elat, input int bp, input string tag);
        int cyc;
        int w;
        @(negedge clk);
        a        = ta;
        shamt    = ts;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        shamt    = 5'($urandom_range(0, 31));
        @(negedge clk);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(elat));
        chk({tag, "_y"}, y, ey);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_bp_y"}, y, ey);
            chk({tag, "_bp_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_after_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int          saw_valid;
        logic [31:0] ra;
        logic [4:0]  rs;

        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        shamt     = 5'd0;

        vecs[0] = '{32'hF000_0000, 5'd0,  32'hF000_0000, 1};
        vecs[1] = '{32'hFFFF_FFFF, 5'd5,  32'h07FF_FFFF, 3};
        vecs[2] = '{32'h8000_0000, 5'd31, 32'h0000_0001, 9};
        vecs[3] = '{32'h1234_5678, 5'd4,  32'h0123_4567, 2};
        vecs[4] = '{32'h1234_5678, 5'd8,  32'h0012_3456, 3};
        vecs[5] = '{32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD, 5};
        vecs[6] = '{32'h8000_0000, 5'd1,  32'h4000_0000, 2};
        vecs[7] = '{32'hAAAA_AAAA, 5'd3,  32'h1555_5555, 2};
        vecs[8] = '{32'hFFFF_FFFF, 5'd7,  32'h01FF_FFFF, 3};

        // Asynchronous reset asserted between clock edges.
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].sh, vecs[i].exp_y, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid held high across DONE.
        @(negedge clk);
        a        = 32'h1234_5678;
        shamt    = 5'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_cyc1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("hold_cyc2_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_y", y, 32'h0123_4567);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_bp_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_bp_y", y, 32'h0123_4567);
            chk("hold_bp_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_bp_busy", {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        a         = 32'h0000_00F0;
        shamt     = 5'd4;
        @(negedge clk);
        chk("hold_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("hold_idle_busy", {31'd0, busy}, 32'd0);
        chk("hold_idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_second_busy", {31'd0, busy}, 32'd1);
        chk("hold_second_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("hold_second_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_second_y", y, 32'h0000_000F);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_extra_accept", {31'd0, busy}, 32'd0);
        end

        // Reset pulse in the middle of a long shift.
        @(negedge clk);
        a        = 32'hFFFF_FFFF;
        shamt    = 5'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_y", y, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_rel_ready", {31'd0, in_ready}, 32'd1);
        saw_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("abort_no_result", 32'(saw_valid), 32'd0);
        do_op(32'h0000_0100, 5'd8, 32'h0000_0001, 3, 0, "post_abort");

        // Randomized scoreboard, alternating with and without backpressure.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            do_op(ra, rs, ra >> rs, 1 + (int'(rs) + STEP - 1) / STEP,
                  (i % 2 == 0) ? 0 : int'($urandom_range(1, 3)), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
